// File: rtl/exe_unit_core.sv
// Registered signed ALU: one-cycle latency result plus OF/SF/BF/VF status flags.
// Optional build macro EXE_UNIT_SAT_EN saturates add/sub/negate on overflow.
module exe_unit_core #(
    parameter int M = 8,
    parameter int N = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [M-1:0] i_argA,
    input  logic [M-1:0] i_argB,
    input  logic [N-1:0] i_oper,
    output logic [M-1:0] o_result,
    output logic         o_OF,
    output logic         o_SF,
    output logic         o_BF,
    output logic         o_VF
);

    localparam int SW = $clog2(M);
    localparam logic [M-1:0] SMAX = {1'b0, {(M-1){1'b1}}};
    localparam logic [M-1:0] SMIN = {1'b1, {(M-1){1'b0}}};

    typedef enum logic [N-1:0] {
        OP_ADD = 0,
        OP_SUB = 1,
        OP_AND = 2,
        OP_OR  = 3,
        OP_XOR = 4,
        OP_NOT = 5,
        OP_SHL = 6,
        OP_SHR = 7,
        OP_SRA = 8,
        OP_SGT = 9,
        OP_NEG = 10
    } opcode_e;

    logic [M:0]    a_ext;
    logic [M:0]    b_ext;
    logic [M:0]    wide;
    logic          arith;
    logic [SW-1:0] sh;
    logic [M-1:0]  res_d;
    logic          of_d;
    logic          vf_d;

    logic [M-1:0]  result_q;
    logic          of_q;
    logic          sf_q;
    logic          bf_q;
    logic          vf_q;

    always_comb begin
        a_ext = {i_argA[M-1], i_argA};
        b_ext = {i_argB[M-1], i_argB};
        sh    = i_argB[SW-1:0];
        wide  = '0;
        arith = 1'b0;
        res_d = '0;
        of_d  = 1'b0;
        vf_d  = 1'b0;
        case (i_oper)
            OP_ADD: begin wide = a_ext + b_ext; arith = 1'b1; end
            OP_SUB: begin wide = a_ext - b_ext; arith = 1'b1; end
            OP_NEG: begin wide = '0 - a_ext;    arith = 1'b1; end
            OP_AND: res_d = i_argA & i_argB;
            OP_OR:  res_d = i_argA | i_argB;
            OP_XOR: res_d = i_argA ^ i_argB;
            OP_NOT: res_d = ~i_argA;
            OP_SHL: res_d = i_argA << sh;
            OP_SHR: res_d = i_argA >> sh;
            OP_SRA: res_d = $signed(i_argA) >>> sh;
            OP_SGT: res_d = {{(M-1){1'b0}}, ($signed(i_argA) > $signed(i_argB))};
            default: vf_d = 1'b1;
        endcase
        // One guard bit: overflow when it disagrees with the result sign; it also gives the true sign.
        if (arith) begin
            of_d = wide[M] ^ wide[M-1];
`ifdef EXE_UNIT_SAT_EN
            res_d = of_d ? (wide[M] ? SMIN : SMAX) : wide[M-1:0];
`else
            res_d = wide[M-1:0];
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            result_q <= '0;
            of_q     <= 1'b0;
            sf_q     <= 1'b0;
            bf_q     <= 1'b0;
            vf_q     <= 1'b0;
        end else begin
            result_q <= res_d;
            of_q     <= of_d;
            sf_q     <= res_d[M-1];
            bf_q     <= ~^res_d;
            vf_q     <= vf_d;
        end
    end

    assign o_result = result_q;
    assign o_OF     = of_q;
    assign o_SF     = sf_q;
    assign o_BF     = bf_q;
    assign o_VF     = vf_q;

endmodule

// File: tb/tb_exe_unit_core.sv
// Self-checking bench for exe_unit_core: directed vector table, reset sequences, randomized model check.
module tb_exe_unit_core;

    logic       clk;
    logic       rst_n;
    logic [7:0] arg_a;
    logic [7:0] arg_b;
    logic [3:0] oper;
    logic [7:0] result;
    logic       of_f, sf_f, bf_f, vf_f;

    int n_cmp = 0;
    int n_err = 0;

    exe_unit_core #(.M(8), .N(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_argA  (arg_a),
        .i_argB  (arg_b),
        .i_oper  (oper),
        .o_result(result),
        .o_OF    (of_f),
        .o_SF    (sf_f),
        .o_BF    (bf_f),
        .o_VF    (vf_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [11:0] exp;   // {result, OF, SF, BF, VF}
    } vec_t;

    vec_t tbl[$];

    function automatic logic [11:0] outs();
        return {result, of_f, sf_f, bf_f, vf_f};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got res=%h OF%b SF%b BF%b VF%b, expected res=%h OF%b SF%b BF%b VF%b",
                     name, act[11:4], act[3], act[2], act[1], act[0],
                     exp[11:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic add_vec(input string name, input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [11:0] exp);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic step(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        oper = op; arg_a = a; arg_b = b;
        @(posedge clk);
        #1;
    endtask

    // Reference model from the arithmetic rules, using integers and floor division.
    function automatic logic [11:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int sa, sb, ua, sh, t, ones;
        logic [7:0] r;
        logic of, vf;
        sa = $signed(a);
        sb = $signed(b);
        ua = int'(a);
        sh = int'(b[2:0]);
        r = 8'h00; of = 1'b0; vf = 1'b0; t = 0;
        case (op)
            4'd0, 4'd1, 4'd10: begin
                if (op == 4'd0)      t = sa + sb;
                else if (op == 4'd1) t = sa - sb;
                else                 t = -sa;
                of = (t > 127) || (t < -128);
`ifdef EXE_UNIT_SAT_EN
                if (t > 127)       t = 127;
                else if (t < -128) t = -128;
`endif
                r = t[7:0];
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6: begin t = (ua * (1 << sh)) % 256; r = t[7:0]; end
            4'd7: begin t = ua / (1 << sh); r = t[7:0]; end
            4'd8: begin
                t = sa / (1 << sh);
                if (sa < 0 && (sa % (1 << sh)) != 0) t = t - 1;
                r = t[7:0];
            end
            4'd9: r = (sa > sb) ? 8'h01 : 8'h00;
            default: begin r = 8'h00; vf = 1'b1; end
        endcase
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(r[i]);
        return {r, of, r[7], (ones % 2 == 0), vf};
    endfunction

    initial begin
        rst_n = 1'b0; arg_a = 8'h00; arg_b = 8'h00; oper = 4'd0;

        add_vec("add_3_4",      4'd0,  8'h03, 8'h04, {8'h07, 4'b0000});
`ifdef EXE_UNIT_SAT_EN
        add_vec("add_ovf_pos",  4'd0,  8'h7F, 8'h01, {8'h7F, 4'b1000});
        add_vec("neg_min",      4'd10, 8'h80, 8'h00, {8'h7F, 4'b1000});
        add_vec("sub_ovf_neg",  4'd1,  8'h80, 8'h01, {8'h80, 4'b1100});
`else
        add_vec("add_ovf_pos",  4'd0,  8'h7F, 8'h01, {8'h80, 4'b1100});
        add_vec("neg_min",      4'd10, 8'h80, 8'h00, {8'h80, 4'b1100});
        add_vec("sub_ovf_neg",  4'd1,  8'h80, 8'h01, {8'h7F, 4'b1000});
`endif
        add_vec("sub_5_7",      4'd1,  8'h05, 8'h07, {8'hFE, 4'b0100});
        add_vec("sra_90_2",     4'd8,  8'h90, 8'h02, {8'hE4, 4'b0110});
        add_vec("shl_81_1",     4'd6,  8'h81, 8'h01, {8'h02, 4'b0000});
        add_vec("sgt_m1_1",     4'd9,  8'hFF, 8'h01, {8'h00, 4'b0010});
        add_vec("sgt_1_m1",     4'd9,  8'h01, 8'hFF, {8'h01, 4'b0000});
        add_vec("sgt_equal",    4'd9,  8'h05, 8'h05, {8'h00, 4'b0010});
        add_vec("invalid_12",   4'd12, 8'h5A, 8'h33, {8'h00, 4'b0011});
        add_vec("and_clr_vf",   4'd2,  8'hF0, 8'h3C, {8'h30, 4'b0010});
        add_vec("shr_sh0",      4'd7,  8'h80, 8'h08, {8'h80, 4'b0100});
        add_vec("not_0f",       4'd5,  8'h0F, 8'h00, {8'hF0, 4'b0110});
        add_vec("or_a0_05",     4'd3,  8'hA0, 8'h05, {8'hA5, 4'b0110});
        add_vec("xor_ff_0f",    4'd4,  8'hFF, 8'h0F, {8'hF0, 4'b0110});
        add_vec("neg_5",        4'd10, 8'h05, 8'h00, {8'hFB, 4'b0100});
        add_vec("invalid_15",   4'd15, 8'hFF, 8'hFF, {8'h00, 4'b0011});

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", outs(), 12'h000);

        @(negedge clk);
        rst_n = 1'b1; oper = 4'd0; arg_a = 8'h03; arg_b = 8'h04;
        @(posedge clk);
        #1;
        check("first_after_reset", outs(), {8'h07, 4'b0000});

        foreach (tbl[i]) begin
            step(tbl[i].op, tbl[i].a, tbl[i].b);
            check(tbl[i].name, outs(), tbl[i].exp);
        end

        // Mid-run reset: outputs clear asynchronously and hold, then resume on the first edge after release.
        step(4'd1, 8'h05, 8'h07);
        check("pre_reset", outs(), {8'hFE, 4'b0100});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", outs(), 12'h000);
        oper = 4'd5; arg_a = 8'h00;
        @(posedge clk);
        #1;
        check("held_in_reset", outs(), 12'h000);
        @(negedge clk);
        rst_n = 1'b1; oper = 4'd0; arg_a = 8'h03; arg_b = 8'h04;
        @(posedge clk);
        #1;
        check("release_add", outs(), {8'h07, 4'b0000});

        for (int n = 0; n < 2000; n++) begin
            logic [3:0] op;
            logic [7:0] a, b;
            op = 4'($urandom_range(15, 0));
            a  = 8'($urandom);
            b  = 8'($urandom);
            if (n % 16 == 0) a = 8'h80;
            if (n % 16 == 1) a = 8'h7F;
            step(op, a, b);
            check("random", outs(), model(op, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
